hx8357_read_controller: RTL and testbench
=========================================

Name: hx8357_read_controller

Overview:
- Read-side companion to the HX8357 8080-style parallel write controller.
- Issues one command write (DCx=0), releases the bus, then performs N read cycles (DCx=1, RDx strobes). It captures DATAx on each RDx rising edge and hands words to the user via a valid/ready handshake.
- Used for ID reads, status reads and frame-memory readback (RAMRD). The top level muxes its pins with the write controller; only one controller owns the bus at a time, and `busy` gates the arbitration.

Parameters:
- RD_LOW_CYC, 4, clk cycles RDx is held low per read (>=1).
- RD_HIGH_CYC, 2, minimum clk cycles RDx is held high between reads (>=1).
- TURN_CYC, 1, clk cycles between bus release (DATAx_oe=0) and the first RDx fall (>=1).
- DUMMY_READ, 1, 1 = one extra leading read whose data is discarded (HX8357 dummy read); 0 = none.

Ports:
- clk  in  1  clock.
- nres  in  1  asynchronous reset, active low.
- start  in  1  single-cycle request; sampled only in IDLE.
- cmd_in  in  16  command word; latched on accepted start.
- rd_count  in  8  number of data words to deliver; latched on accepted start.
- busy  out  1  high from the cycle after start acceptance until done.
- rd_data  out  16  captured read word.
- rd_valid  out  1  rd_data valid; held until accepted.
- rd_ready  in  1  consumer accepts when rd_valid && rd_ready.
- done  out  1  one-cycle pulse when the transaction ends.
- CSx  out  1  chip select, active low.
- DCx  out  1  0 = command, 1 = data.
- WRx  out  1  write strobe, active low.
- RDx  out  1  read strobe, active low.
- DATAx_out  out  16  driven bus value.
- DATAx_oe  out  1  1 = controller drives DATAx.
- DATAx_in  in  16  bus value from the display (pad input).

Behaviour:
- Reset (async, immediate, including mid-transaction) forces all outputs to idle:
  - CSx=1, DCx=1, WRx=1, RDx=1, DATAx_out=0, DATAx_oe=0.
  - busy=0, rd_valid=0, rd_data=0, done=0.
  - State=IDLE, counters=0.
- States and transitions:
  - IDLE: on start, latch cmd_in and rd_count, go to CMD_SETUP. start while not in IDLE is ignored.
  - CMD_SETUP (1 cycle): CSx=0, DCx=0, DATAx_out=cmd, DATAx_oe=1, busy=1. Go to CMD_WR.
  - CMD_WR (1 cycle): WRx=0, data held. Go to CMD_HOLD.
  - CMD_HOLD (1 cycle): WRx=1, data still held. Go to TURN; if total reads = 0, go to FINISH.
  - TURN (TURN_CYC cycles): DATAx_oe=0, DCx=1. Go to RD_LOW.
  - RD_LOW (RD_LOW_CYC cycles): RDx=0. On the edge leaving this state, RDx=1 and DATAx_in is registered into the capture register. Go to RD_HIGH.
  - RD_HIGH: RDx=1.
    - Dummy read: the captured word is dropped; no rd_valid.
    - Data read: rd_data is loaded with the captured word and rd_valid=1 on the same edge RD_HIGH is entered.
    - Leave after RD_HIGH_CYC cycles AND (rd_valid=0 or accepted this cycle).
    - Next state is RD_LOW if reads remain, else FINISH.
  - FINISH: wait until rd_valid=0 (last word accepted). Then CSx=1, DCx=1, done=1 for one cycle, busy=0, go to IDLE.
- Read count:
  - Total read strobes = rd_count + DUMMY_READ.
  - rd_count=0 with DUMMY_READ=1: one dummy strobe, zero words delivered.
  - rd_count=0 with DUMMY_READ=0: command write only.
  - rd_count=255: 8-bit down-counter decrements per strobe; no wrap; exactly 255 words delivered.
- Backpressure:
  - rd_valid stays high and rd_data stable until accepted.
  - RDx never falls while an unaccepted word is pending, so there is no overrun and no data loss.
  - Acceptance and the next capture can occur on the same edge: rd_valid stays 1 and rd_data updates.
- Bus safety:
  - DATAx_oe=0 whenever RDx=0.
  - WRx and RDx are never low simultaneously.
  - CSx stays low continuously from CMD_SETUP through the last RD_HIGH.
- Latency (defaults, start accepted at edge E0):
  - First (dummy) RDx fall at E4; capture at E8.
  - First data RDx fall at E10; first rd_valid at E14.

Test Plan:
- Basic: cmd_in=0x0004, rd_count=3, DUMMY_READ=1, rd_ready=1, display model returns 0xAAAA, 0x1111, 0x2222, 0x3333 → exactly one WRx pulse with DCx=0 and DATAx_out=0x0004, then 4 RDx pulses; rd_data sequence 0x1111, 0x2222, 0x3333; done pulses once; CSx low throughout.
- Backpressure: same command with rd_ready held 0 for 20 cycles after the first rd_valid → RDx stays high, rd_data stays 0x1111; after release, the remaining words are delivered in order with no loss.
- Empty: rd_count=0, DUMMY_READ=0 → one WRx pulse, zero RDx pulses, rd_valid never set, done 3 cycles after acceptance.
- Start while busy: pulse start mid-read with a different cmd_in → ignored; the original transaction completes unchanged.
- Reset mid-read: assert nres=0 while RDx=0 → same-cycle asynchronous return to all idle outputs (RDx=1, CSx=1, oe=0, rd_valid=0); a fresh start afterwards works.
- Timing check: parameters 3/3/2 → every RDx low exactly 3 cycles, high >=3 cycles, 2 cycles from oe=0 to the first RDx fall, and oe never 1 while RDx=0.

Source files
------------

// File: rtl/hx8357_read_controller.sv
// ---------------------------------------------------------------------------
// hx8357_read_controller
//
// Purpose:
//   Read-side master for an HX8357 8080-style parallel bus. One transaction
//   writes a command word (DCx=0, one WRx pulse), releases the bus, then
//   issues rd_count (+1 optional dummy) RDx strobes and delivers each captured
//   DATAx word through a valid/ready handshake. busy lets a top-level arbiter
//   decide which controller owns the shared pins.
//
// Ports:
//   clk, nres            clock, asynchronous active-low reset
//   start                request, sampled only while idle
//   cmd_in, rd_count     command word and number of words to deliver
//   busy, done           transaction in progress / one-cycle end pulse
//   rd_data, rd_valid    captured word and its valid flag
//   rd_ready             consumer accept
//   CSx, DCx, WRx, RDx   bus control pins (CSx/WRx/RDx active low)
//   DATAx_out, DATAx_oe  bus drive value and output enable
//   DATAx_in             bus value from the pad
// ---------------------------------------------------------------------------
module hx8357_read_controller #(
  parameter int unsigned RD_LOW_CYC  = 4,
  parameter int unsigned RD_HIGH_CYC = 2,
  parameter int unsigned TURN_CYC    = 1,
  parameter bit          DUMMY_READ  = 1'b1
) (
  input  logic        clk,
  input  logic        nres,
  input  logic        start,
  input  logic [15:0] cmd_in,
  input  logic [7:0]  rd_count,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        done,
  output logic        CSx,
  output logic        DCx,
  output logic        WRx,
  output logic        RDx,
  output logic [15:0] DATAx_out,
  output logic        DATAx_oe,
  input  logic [15:0] DATAx_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_SETUP, S_CMD_WR, S_CMD_HOLD,
    S_TURN, S_RD_LOW, S_RD_HIGH, S_FINISH
  } state_t;

  // All pin-level outputs are registered so the pads never see decode glitches.
  typedef struct packed {
    logic        cs_n;
    logic        dc;
    logic        wr_n;
    logic        rd_n;
    logic        oe;
    logic        busy;
    logic        done;
    logic [15:0] dout;
  } pins_t;

  localparam pins_t PINS_IDLE = '{cs_n: 1'b1, dc: 1'b1, wr_n: 1'b1, rd_n: 1'b1,
                                  oe: 1'b0, busy: 1'b0, done: 1'b0, dout: 16'h0000};

  localparam logic [7:0] TURN_LAST = 8'(TURN_CYC - 1);
  localparam logic [7:0] LOW_LAST  = 8'(RD_LOW_CYC - 1);
  localparam logic [7:0] HIGH_LAST = 8'(RD_HIGH_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic [7:0]  words_q, words_d;     // data words still to be strobed
  logic        dummy_q, dummy_d;     // dummy strobe still pending
  logic [7:0]  cyc_q, cyc_d;         // cycles spent in the current state
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  pins_t       pins_q, pins_d;
  logic        reads_left;
  logic        accept;

  function automatic pins_t pins_for(input state_t s, input logic valid,
                                     input logic [15:0] cmd);
    pins_t p;
    p = PINS_IDLE;
    case (s)
      S_CMD_SETUP, S_CMD_HOLD: begin
        p.cs_n = 1'b0; p.dc = 1'b0; p.oe = 1'b1; p.dout = cmd; p.busy = 1'b1;
      end
      S_CMD_WR: begin
        p.cs_n = 1'b0; p.dc = 1'b0; p.oe = 1'b1; p.dout = cmd; p.busy = 1'b1;
        p.wr_n = 1'b0;
      end
      S_TURN, S_RD_HIGH: begin
        p.cs_n = 1'b0; p.busy = 1'b1;
      end
      S_RD_LOW: begin
        p.cs_n = 1'b0; p.busy = 1'b1; p.rd_n = 1'b0;
      end
      S_FINISH: begin
        // Keep the chip selected until the last word has been taken.
        if (valid) begin
          p.cs_n = 1'b0; p.busy = 1'b1;
        end else begin
          p.done = 1'b1;
        end
      end
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

  // Counters are already post-decrement when RD_HIGH is entered.
  assign reads_left = dummy_q || (words_q != 8'd0);
  assign accept     = rd_valid_q && rd_ready;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    words_d    = words_q;
    dummy_d    = dummy_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    cyc_d      = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;

    if (accept) rd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d   = cmd_in;
          words_d = rd_count;
          dummy_d = DUMMY_READ;
          state_d = S_CMD_SETUP;
        end
      end
      S_CMD_SETUP: state_d = S_CMD_WR;
      S_CMD_WR:    state_d = S_CMD_HOLD;
      S_CMD_HOLD:  state_d = reads_left ? S_TURN : S_FINISH;
      S_TURN: begin
        if (cyc_q == TURN_LAST) state_d = S_RD_LOW;
      end
      S_RD_LOW: begin
        if (cyc_q == LOW_LAST) begin
          state_d = S_RD_HIGH;
          if (dummy_q) begin
            dummy_d = 1'b0;
          end else begin
            rd_data_d  = DATAx_in;
            rd_valid_d = 1'b1;
            words_d    = words_q - 8'd1;
          end
        end
      end
      S_RD_HIGH: begin
        // Never start another strobe while an untaken word is pending.
        if ((cyc_q >= HIGH_LAST) && (!rd_valid_q || rd_ready))
          state_d = reads_left ? S_RD_LOW : S_FINISH;
      end
      S_FINISH: begin
        if (!rd_valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || (state_q == S_IDLE)) cyc_d = 8'd0;

    pins_d = pins_for(state_d, rd_valid_d, cmd_d);
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q    <= S_IDLE;
      cmd_q      <= 16'h0000;
      words_q    <= 8'd0;
      dummy_q    <= 1'b0;
      cyc_q      <= 8'd0;
      rd_data_q  <= 16'h0000;
      rd_valid_q <= 1'b0;
      pins_q     <= PINS_IDLE;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      words_q    <= words_d;
      dummy_q    <= dummy_d;
      cyc_q      <= cyc_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      pins_q     <= pins_d;
    end
  end

  assign CSx       = pins_q.cs_n;
  assign DCx       = pins_q.dc;
  assign WRx       = pins_q.wr_n;
  assign RDx       = pins_q.rd_n;
  assign DATAx_oe  = pins_q.oe;
  assign DATAx_out = pins_q.dout;
  assign busy      = pins_q.busy;
  assign done      = pins_q.done;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_hx8357_read_controller.sv
// ---------------------------------------------------------------------------
// tb_hx8357_read_controller
//
// Two instances: dut1 with default timing and a dummy read, dut2 with
// RD_LOW/RD_HIGH/TURN = 3/3/2 and no dummy read. A display model feeds each
// strobe a word from a random table; the expected word stream is simply the
// table entries that follow the dummy strobe, in order.
// ---------------------------------------------------------------------------
module tb_hx8357_read_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nres;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] disp_arr [0:1023];

  // ---------------- dut1 ----------------
  logic        start1, busy1, val1, rdy1, done1, cs1, dc1, wr1, rd1, oe1;
  logic [15:0] cmd1, rdd1, dout1, din1;
  logic [7:0]  cnt1;
  int          strobes1 = 0;
  assign din1 = disp_arr[strobes1[9:0]];

  hx8357_read_controller dut1 (
    .clk(clk), .nres(nres), .start(start1), .cmd_in(cmd1), .rd_count(cnt1),
    .busy(busy1), .rd_data(rdd1), .rd_valid(val1), .rd_ready(rdy1), .done(done1),
    .CSx(cs1), .DCx(dc1), .WRx(wr1), .RDx(rd1), .DATAx_out(dout1),
    .DATAx_oe(oe1), .DATAx_in(din1)
  );

  // ---------------- dut2 ----------------
  logic        start2, busy2, val2, rdy2, done2, cs2, dc2, wr2, rd2, oe2;
  logic [15:0] cmd2, rdd2, dout2, din2;
  logic [7:0]  cnt2;
  int          strobes2 = 0;
  assign din2 = disp_arr[10'(strobes2 + 600)];

  hx8357_read_controller #(.RD_LOW_CYC(3), .RD_HIGH_CYC(3), .TURN_CYC(2), .DUMMY_READ(1'b0)) dut2 (
    .clk(clk), .nres(nres), .start(start2), .cmd_in(cmd2), .rd_count(cnt2),
    .busy(busy2), .rd_data(rdd2), .rd_valid(val2), .rd_ready(rdy2), .done(done2),
    .CSx(cs2), .DCx(dc2), .WRx(wr2), .RDx(rd2), .DATAx_out(dout2),
    .DATAx_oe(oe2), .DATAx_in(din2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- bus monitor for dut1 ----------------
  int          wr_cnt1 = 0, fall_cnt1 = 0, done_cnt1 = 0;
  logic [15:0] wr_data1_q[$];
  logic        wr_dc1_q[$];
  int          fall_cyc1[$];
  int          vrise_cyc1[$];
  logic [15:0] got1[$];
  logic        p_rd1, p_wr1, p_cs1, p_val1, p_rdy1;
  logic [15:0] p_data1;

  always @(negedge clk) begin
    if (!nres) begin
      p_rd1 = rd1; p_wr1 = wr1; p_cs1 = cs1; p_val1 = 1'b0; p_rdy1 = 1'b1; p_data1 = rdd1;
    end else begin
      if (!wr1 && p_wr1) begin
        wr_cnt1++; wr_data1_q.push_back(dout1); wr_dc1_q.push_back(dc1);
      end
      if (!rd1 && p_rd1) begin
        fall_cnt1++; fall_cyc1.push_back(cyc);
      end
      if (rd1 && !p_rd1) strobes1++;
      if (!rd1) begin
        chk("d1_oe_while_rd_low", 32'(oe1), 32'd0);
        chk("d1_wr_while_rd_low", 32'(wr1), 32'd1);
      end
      if (val1 && !p_val1) vrise_cyc1.push_back(cyc);
      if (p_val1 && !p_rdy1) begin
        chk("d1_bp_valid_held", 32'(val1), 32'd1);
        chk("d1_bp_data_held", 32'(rdd1), 32'(p_data1));
        chk("d1_bp_no_rd_fall", 32'(rd1), 32'd1);
      end
      if (cs1 && !p_cs1) chk("d1_cs_rise_only_at_done", 32'(done1), 32'd1);
      if (done1) done_cnt1++;
      if (val1 && rdy1) got1.push_back(rdd1);
      p_rd1 = rd1; p_wr1 = wr1; p_cs1 = cs1; p_val1 = val1; p_rdy1 = rdy1; p_data1 = rdd1;
    end
  end

  // ---------------- bus monitor + timing checker for dut2 ----------------
  int          wr_cnt2 = 0, fall_cnt2 = 0, vcnt2 = 0;
  logic [15:0] wr_data2_q[$];
  int          done_cyc2[$];
  logic [15:0] got2[$];
  logic        p_rd2, p_wr2, p_cs2, seen2 = 1'b0;
  int          lo_run2 = 0, hi_run2 = 0, gap2 = 0;

  always @(negedge clk) begin
    if (!nres) begin
      p_rd2 = rd2; p_wr2 = wr2; p_cs2 = cs2; seen2 = 1'b0; lo_run2 = 0; hi_run2 = 0; gap2 = 0;
    end else begin
      if (!wr2 && p_wr2) begin
        wr_cnt2++; wr_data2_q.push_back(dout2);
      end
      if (oe2) gap2 = 0;
      else if (rd2 && !seen2) gap2++;
      if (!rd2 && p_rd2) begin
        fall_cnt2++;
        if (seen2) chk("d2_rd_high_min3", 32'(hi_run2 >= 3), 32'd1);
        else       chk("d2_oe_off_to_first_fall", 32'(gap2), 32'd2);
        seen2 = 1'b1;
        lo_run2 = 0;
      end
      if (rd2 && !p_rd2) begin
        chk("d2_rd_low_len", 32'(lo_run2), 32'd3);
        strobes2++;
        hi_run2 = 0;
      end
      if (!rd2) lo_run2++;
      else      hi_run2++;
      if (!rd2) begin
        chk("d2_oe_while_rd_low", 32'(oe2), 32'd0);
        chk("d2_wr_while_rd_low", 32'(wr2), 32'd1);
      end
      if (cs2 && !p_cs2) chk("d2_cs_rise_only_at_done", 32'(done2), 32'd1);
      if (val2) vcnt2++;
      if (done2) done_cyc2.push_back(cyc);
      if (val2 && rdy2) got2.push_back(rdd2);
      if (cs2) seen2 = 1'b0;
      p_rd2 = rd2; p_wr2 = wr2; p_cs2 = cs2;
    end
  end

  // ---------------- transaction helpers ----------------
  int b_wr1, b_fall1, b_done1, b_got1, b_str1, b_vr1, e0_1;
  int b_wr2, b_fall2, b_dc2, b_got2, b_str2, b_v2, e0_2;

  task automatic begin_txn1(input logic [15:0] cmd, input logic [7:0] cnt);
    b_wr1 = wr_cnt1; b_fall1 = fall_cnt1; b_done1 = done_cnt1; b_got1 = got1.size();
    b_str1 = strobes1; b_vr1 = vrise_cyc1.size();
    cmd1 = cmd; cnt1 = cnt; start1 = 1'b1;
    step();
    e0_1 = cyc;
    start1 = 1'b0; cmd1 = 16'($urandom); cnt1 = 8'($urandom);
  endtask

  task automatic end_txn1(input logic [15:0] cmd, input int cnt, input int budget, input bit rand_rdy);
    int k;
    k = 0;
    while (done_cnt1 == b_done1 && k < budget) begin
      if (rand_rdy) rdy1 = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    rdy1 = 1'b1;
    chk("d1_done_pulses", 32'(done_cnt1 - b_done1), 32'd1);
    chk("d1_wr_pulses", 32'(wr_cnt1 - b_wr1), 32'd1);
    chk("d1_cmd_data", (wr_data1_q.size() > b_wr1) ? 32'(wr_data1_q[b_wr1]) : 32'hDEAD0000, 32'(cmd));
    chk("d1_cmd_dcx", (wr_dc1_q.size() > b_wr1) ? 32'(wr_dc1_q[b_wr1]) : 32'hDEAD0000, 32'd0);
    chk("d1_rd_strobes", 32'(fall_cnt1 - b_fall1), 32'(cnt + 1));
    chk("d1_word_count", 32'(got1.size() - b_got1), 32'(cnt));
    for (int i = 0; i < cnt; i++)
      chk("d1_word", (b_got1 + i < got1.size()) ? 32'(got1[b_got1 + i]) : 32'hDEADBEEF,
          32'(disp_arr[10'(b_str1 + 1 + i)]));
  endtask

  task automatic begin_txn2(input logic [15:0] cmd, input logic [7:0] cnt);
    b_wr2 = wr_cnt2; b_fall2 = fall_cnt2; b_dc2 = done_cyc2.size(); b_got2 = got2.size();
    b_str2 = strobes2; b_v2 = vcnt2;
    cmd2 = cmd; cnt2 = cnt; start2 = 1'b1;
    step();
    e0_2 = cyc;
    start2 = 1'b0; cmd2 = 16'($urandom); cnt2 = 8'($urandom);
  endtask

  task automatic end_txn2(input logic [15:0] cmd, input int cnt, input int budget, input bit rand_rdy);
    int k;
    k = 0;
    while (done_cyc2.size() == b_dc2 && k < budget) begin
      if (rand_rdy) rdy2 = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    rdy2 = 1'b1;
    chk("d2_done_pulses", 32'(done_cyc2.size() - b_dc2), 32'd1);
    chk("d2_wr_pulses", 32'(wr_cnt2 - b_wr2), 32'd1);
    chk("d2_cmd_data", (wr_data2_q.size() > b_wr2) ? 32'(wr_data2_q[b_wr2]) : 32'hDEAD0000, 32'(cmd));
    chk("d2_rd_strobes", 32'(fall_cnt2 - b_fall2), 32'(cnt));
    chk("d2_word_count", 32'(got2.size() - b_got2), 32'(cnt));
    for (int i = 0; i < cnt; i++)
      chk("d2_word", (b_got2 + i < got2.size()) ? 32'(got2[b_got2 + i]) : 32'hDEADBEEF,
          32'(disp_arr[10'(600 + b_str2 + i)]));
  endtask

  task automatic wait_rd_low1(input int budget);
    int k;
    k = 0;
    while (rd1 !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    chk("d1_rd_low_reached", 32'(rd1), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] c;
    int          n;
    int          k;

    for (int i = 0; i < 1024; i++) disp_arr[i] = 16'($urandom);
    disp_arr[0] = 16'hAAAA; disp_arr[1] = 16'h1111;
    disp_arr[2] = 16'h2222; disp_arr[3] = 16'h3333;

    nres = 1'b0;
    start1 = 1'b0; cmd1 = 16'h0; cnt1 = 8'd0; rdy1 = 1'b1;
    start2 = 1'b0; cmd2 = 16'h0; cnt2 = 8'd0; rdy2 = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_d1_csx", 32'(cs1), 32'd1);
    chk("rst_d1_dcx", 32'(dc1), 32'd1);
    chk("rst_d1_wrx", 32'(wr1), 32'd1);
    chk("rst_d1_rdx", 32'(rd1), 32'd1);
    chk("rst_d1_dout", 32'(dout1), 32'd0);
    chk("rst_d1_oe", 32'(oe1), 32'd0);
    chk("rst_d1_busy", 32'(busy1), 32'd0);
    chk("rst_d1_valid", 32'(val1), 32'd0);
    chk("rst_d1_rdata", 32'(rdd1), 32'd0);
    chk("rst_d1_done", 32'(done1), 32'd0);
    chk("rst_d2_ctrl", 32'({cs2, dc2, wr2, rd2, oe2, busy2, val2, done2}), 32'b11110000);
    nres = 1'b1;
    step();

    // Basic read with dummy: words 1111/2222/3333, check latency
    begin_txn1(16'h0004, 8'd3);
    end_txn1(16'h0004, 3, 200, 1'b0);
    chk("lat_first_fall", (fall_cyc1.size() > b_fall1) ? 32'(fall_cyc1[b_fall1] - e0_1) : 32'hFFFFFFFF, 32'd4);
    chk("lat_second_fall", (fall_cyc1.size() > b_fall1 + 1) ? 32'(fall_cyc1[b_fall1 + 1] - e0_1) : 32'hFFFFFFFF, 32'd10);
    chk("lat_first_valid", (vrise_cyc1.size() > b_vr1) ? 32'(vrise_cyc1[b_vr1] - e0_1) : 32'hFFFFFFFF, 32'd14);
    step();

    // Backpressure: hold rd_ready low for 20 cycles after the first word
    rdy1 = 1'b0;
    begin_txn1(16'h0004, 8'd3);
    k = 0;
    while (!val1 && k < 100) begin step(); k++; end
    chk("bp_valid_seen", 32'(val1), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_rdx_high", 32'(rd1), 32'd1);
      chk("bp_data_stable", 32'(rdd1), 32'(disp_arr[10'(b_str1 + 1)]));
    end
    rdy1 = 1'b1;
    end_txn1(16'h0004, 3, 200, 1'b0);
    step();

    // Random commands and counts with random consumer stalls
    for (int t = 0; t < 4; t++) begin
      c = 16'($urandom);
      n = $urandom_range(1, 12);
      begin_txn1(c, 8'(n));
      end_txn1(c, n, 2000, 1'b1);
      step();
    end

    // Dummy strobe only
    begin_txn1(16'h00DA, 8'd0);
    end_txn1(16'h00DA, 0, 200, 1'b0);
    step();

    // Largest count: no counter wrap
    begin_txn1(16'h002E, 8'd255);
    end_txn1(16'h002E, 255, 5000, 1'b0);
    step();

    // Start while busy is ignored
    begin_txn1(16'h00D3, 8'd4);
    wait_rd_low1(100);
    cmd1 = 16'h1234; cnt1 = 8'd9; start1 = 1'b1;
    step();
    start1 = 1'b0;
    end_txn1(16'h00D3, 4, 500, 1'b0);
    k = wr_cnt1;
    repeat (10) step();
    chk("busy_start_no_new_txn", 32'(wr_cnt1 - k), 32'd0);
    chk("busy_start_idle_after", 32'(busy1), 32'd0);

    // Reset in the middle of a read strobe
    begin_txn1(16'h0009, 8'd5);
    wait_rd_low1(100);
    #2;
    nres = 1'b0;
    #1;
    chk("mid_rst_rdx", 32'(rd1), 32'd1);
    chk("mid_rst_csx", 32'(cs1), 32'd1);
    chk("mid_rst_oe", 32'(oe1), 32'd0);
    chk("mid_rst_valid", 32'(val1), 32'd0);
    chk("mid_rst_rest", 32'({busy1, done1, wr1, dc1}), 32'b0011);
    chk("mid_rst_data", 32'({dout1, rdd1}), 32'd0);
    step();
    nres = 1'b1;
    step();
    begin_txn1(16'h000A, 8'd2);
    end_txn1(16'h000A, 2, 200, 1'b0);
    step();

    // dut2: command only, then timed reads
    begin_txn2(16'h0001, 8'd0);
    end_txn2(16'h0001, 0, 200, 1'b0);
    chk("d2_empty_no_valid", 32'(vcnt2 - b_v2), 32'd0);
    chk("d2_empty_done_lat", (done_cyc2.size() > b_dc2) ? 32'(done_cyc2[b_dc2] - e0_2) : 32'hFFFFFFFF, 32'd3);
    step();
    c = 16'($urandom);
    begin_txn2(c, 8'd6);
    end_txn2(c, 6, 1000, 1'b1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
